// File: rtl/vc_packet_arbiter.sv
// Packet-locked round-robin read arbiter over NUM_VCS first-word-fall-through VC FIFOs.
// Optional header length check and clamp enabled by defining VC_PKT_ARB_LEN_CHECK_EN.
module vc_packet_arbiter #(
  parameter int NUM_VCS      = 2,
  parameter int MAX_PKT_LEN  = 130,
  parameter int LENGTH_WIDTH = $clog2(MAX_PKT_LEN + 1),
  parameter int DATA_W       = 32,
  localparam int VC_W        = $clog2(NUM_VCS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_VCS-1:0]               vc_valid,
  input  logic [NUM_VCS-1:0][DATA_W-1:0]   vc_rdata,
  output logic [NUM_VCS-1:0]               vc_ren,
  input  logic                             out_ready,
  output logic                             out_valid,
  output logic [DATA_W-1:0]                out_flit,
  output logic                             out_sop,
  output logic                             out_eop,
  output logic [VC_W-1:0]                  active_vc,
  output logic                             locked,
  output logic                             len_err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BODY = 1'b1;

  localparam logic [3:0] FMT_SHORT_READ  = 4'h0;
  localparam logic [3:0] FMT_SHORT_WRITE = 4'h1;
  localparam logic [3:0] FMT_LONG_READ   = 4'h2;
  localparam logic [3:0] FMT_LONG_WRITE  = 4'h3;

  logic [0:0]              state;
  logic [VC_W-1:0]         rr_ptr;
  logic [VC_W-1:0]         lock_vc;
  logic [LENGTH_WIDTH-1:0] remaining;
  logic [VC_W-1:0]         pick;
  logic                    any;
  logic [VC_W-1:0]         idx;
  logic [LENGTH_WIDTH-1:0] total;
  logic [LENGTH_WIDTH-1:0] body_len;
  logic                    xfer;

  function automatic logic [LENGTH_WIDTH-1:0] decode_total(input logic [3:0] fmt,
                                                           input logic [6:0] len);
    logic [LENGTH_WIDTH-1:0] t;
    case (fmt)
      FMT_SHORT_READ, FMT_SHORT_WRITE: t = LENGTH_WIDTH'(1) + LENGTH_WIDTH'(len[3:0]);
      FMT_LONG_READ, FMT_LONG_WRITE:   t = LENGTH_WIDTH'(2) + LENGTH_WIDTH'(len);
      default:                         t = LENGTH_WIDTH'(1) + LENGTH_WIDTH'(len);
    endcase
    return t;
  endfunction

  function automatic logic [VC_W-1:0] next_vc(input logic [VC_W-1:0] v);
    return (int'(v) == NUM_VCS - 1) ? '0 : v + 1'b1;
  endfunction

  // Scan downward so the valid VC closest to rr_ptr (with wrap) wins.
  always_comb begin
    pick = rr_ptr;
    any  = 1'b0;
    idx  = '0;
    for (int i = NUM_VCS - 1; i >= 0; i--) begin
      idx = VC_W'((int'(rr_ptr) + i) % NUM_VCS);
      if (vc_valid[idx]) begin
        pick = idx;
        any  = 1'b1;
      end
    end
  end

  always_comb begin
    if (state == BODY) begin
      active_vc = lock_vc;
      out_valid = vc_valid[lock_vc];
    end else begin
      active_vc = pick;
      out_valid = any;
    end
  end

  assign out_flit = vc_rdata[active_vc];
  assign total    = decode_total(out_flit[31:28], out_flit[6:0]);
  assign out_sop  = (state == IDLE) && out_valid;
  assign out_eop  = (state == BODY) ? (remaining == LENGTH_WIDTH'(1))
                                    : (out_valid && total == LENGTH_WIDTH'(1));
  assign xfer     = out_valid && out_ready;
  assign locked   = (state == BODY);

  always_comb begin
    for (int i = 0; i < NUM_VCS; i++) begin
      vc_ren[i] = xfer && (active_vc == VC_W'(i));
    end
  end

`ifdef VC_PKT_ARB_LEN_CHECK_EN
  logic over;
  logic len_err_r;

  function automatic logic [LENGTH_WIDTH-1:0] sat_len(input logic [LENGTH_WIDTH-1:0] t);
    return (t > LENGTH_WIDTH'(MAX_PKT_LEN)) ? LENGTH_WIDTH'(MAX_PKT_LEN) : t;
  endfunction

  assign over     = total > LENGTH_WIDTH'(MAX_PKT_LEN);
  assign body_len = sat_len(total) - LENGTH_WIDTH'(1);
  assign len_err  = len_err_r;

  always_ff @(posedge clk) begin
    if (rst) len_err_r <= 1'b0;
    else     len_err_r <= xfer && (state == IDLE) && over;
  end
`else
  assign body_len = total - LENGTH_WIDTH'(1);
  assign len_err  = 1'b0;
`endif

  // Header in IDLE either closes a 1-flit packet or locks; BODY counts down to the boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      lock_vc   <= '0;
      remaining <= '0;
    end else if (xfer) begin
      if (state == IDLE) begin
        if (total == LENGTH_WIDTH'(1)) begin
          rr_ptr <= next_vc(active_vc);
        end else begin
          state     <= BODY;
          lock_vc   <= active_vc;
          remaining <= body_len;
        end
      end else begin
        remaining <= remaining - LENGTH_WIDTH'(1);
        if (remaining == LENGTH_WIDTH'(1)) begin
          state  <= IDLE;
          rr_ptr <= next_vc(lock_vc);
        end
      end
    end
  end

endmodule

// File: tb/tb_vc_packet_arbiter.sv
// Directed bench for vc_packet_arbiter (4 VCs, MAX_PKT_LEN=16) with a queue-level reference model.
module tb_vc_packet_arbiter;
  localparam int NV  = 4;
  localparam int MAX = 16;
  localparam int LW  = $clog2(MAX + 1);
`ifdef VC_PKT_ARB_LEN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic [NV-1:0]       vc_valid;
  logic [NV-1:0][31:0] vc_rdata;
  logic [NV-1:0]       vc_ren;
  logic                out_ready;
  logic                out_valid;
  logic [31:0]         out_flit;
  logic                out_sop;
  logic                out_eop;
  logic [1:0]          active_vc;
  logic                locked;
  logic                len_err;

  vc_packet_arbiter #(.NUM_VCS(NV), .MAX_PKT_LEN(MAX), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .vc_valid(vc_valid), .vc_rdata(vc_rdata), .vc_ren(vc_ren),
    .out_ready(out_ready), .out_valid(out_valid), .out_flit(out_flit), .out_sop(out_sop),
    .out_eop(out_eop), .active_vc(active_vc), .locked(locked), .len_err(len_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [NV][256];
  int head [NV];
  int tail [NV];
  bit mask [NV];

  bit m_busy;
  int m_ptr, m_lock, m_left;
  bit m_lenerr;
  int n_lenerr;

  int glog[$];
  bit slog[$];
  bit elog[$];
  bit blog[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] hdr(input logic [3:0] fmt, input int len);
    logic [6:0] l;
    l = 7'(len);
    return {fmt, 21'h0, l};
  endfunction

  // Packet length in flits as the header declares it, wrapped to the counter width.
  function automatic int total_of(input logic [31:0] f);
    int t;
    case (f[31:28])
      4'h0, 4'h1: t = 1 + int'(f[3:0]);
      4'h2, 4'h3: t = 2 + int'(f[6:0]);
      default:    t = 1 + int'(f[6:0]);
    endcase
    return t % (1 << LW);
  endfunction

  task automatic push(input int v, input logic [31:0] f);
    mem[v][tail[v]] = f;
    tail[v]++;
  endtask

  // Header followed by body flits whose format nibble is F with zero length field.
  task automatic push_pkt(input int v, input logic [31:0] h, input int n);
    push(v, h);
    for (int i = 1; i < n; i++) push(v, 32'hF000_0000 | (32'(v) << 16) | (32'(i) << 8));
  endtask

  task automatic flush();
    for (int v = 0; v < NV; v++) begin
      head[v] = 0; tail[v] = 0; mask[v] = 1'b0;
    end
  endtask

  task automatic drive_inputs();
    for (int v = 0; v < NV; v++) begin
      vc_valid[v] = (tail[v] > head[v]) && !mask[v];
      vc_rdata[v] = (tail[v] > head[v]) ? mem[v][head[v]] : 32'h0;
    end
  endtask

  task automatic clear_logs();
    glog.delete(); slog.delete(); elog.delete(); blog.delete();
  endtask

  task automatic cycle();
    int ea, t, ptr_n, lock_n, left_n;
    bit ev, es, ee, ex, busy_n, lerr_n;
    logic [NV-1:0] eren;
    drive_inputs();
    @(negedge clk);
    ev = 1'b0;
    ea = m_ptr;
    es = 1'b0;
    ee = 1'b0;
    if (!m_busy) begin
      for (int k = 0; k < NV; k++) begin
        if (!ev && vc_valid[(m_ptr + k) % NV]) begin
          ev = 1'b1;
          ea = (m_ptr + k) % NV;
        end
      end
      es = ev;
      ee = ev && (total_of(vc_rdata[ea]) == 1);
    end else begin
      ea = m_lock;
      ev = vc_valid[m_lock];
      ee = (m_left == 1);
    end
    ex   = ev && out_ready;
    eren = ex ? NV'(1 << ea) : '0;
    if (!rst) begin
      chk("out_valid", 64'(out_valid), 64'(ev));
      chk("active_vc", 64'(active_vc), 64'(ea));
      chk("out_sop", 64'(out_sop), 64'(es));
      chk("out_eop", 64'(out_eop), 64'(ee));
      chk("vc_ren", 64'(vc_ren), 64'(eren));
      chk("out_flit", 64'(out_flit), 64'(vc_rdata[ea]));
      chk("locked", 64'(locked), 64'(m_busy));
      chk("len_err", 64'(len_err), 64'(m_lenerr));
      if (m_lenerr) n_lenerr++;
    end
    busy_n = m_busy; ptr_n = m_ptr; lock_n = m_lock; left_n = m_left; lerr_n = 1'b0;
    if (ex) begin
      glog.push_back(ea); slog.push_back(es); elog.push_back(ee); blog.push_back(m_busy);
      if (!m_busy) begin
        t = total_of(vc_rdata[ea]);
        if (t == 1) ptr_n = (ea + 1) % NV;
        else begin
          busy_n = 1'b1;
          lock_n = ea;
          left_n = ((CHK && t > MAX) ? MAX : t) - 1;
          lerr_n = CHK && (t > MAX);
        end
      end else begin
        left_n = m_left - 1;
        if (left_n == 0) begin
          busy_n = 1'b0;
          ptr_n  = (m_lock + 1) % NV;
        end
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_busy = 1'b0; m_ptr = 0; m_lock = 0; m_left = 0; m_lenerr = 1'b0;
    end else begin
      m_busy = busy_n; m_ptr = ptr_n; m_lock = lock_n; m_left = left_n; m_lenerr = lerr_n;
    end
    if (ex) head[ea]++;
  endtask

  task automatic drain(input int budget);
    int n;
    bit pending;
    n = 0;
    pending = 1'b1;
    while (pending && n < budget) begin
      cycle();
      n++;
      pending = m_busy;
      for (int v = 0; v < NV; v++) if (tail[v] > head[v]) pending = 1'b1;
    end
    if (pending) chk("drain_timeout", 64'(1), 64'(0));
  endtask

  initial begin
    int first_eop;
    flush();
    m_busy = 1'b0; m_ptr = 0; m_lock = 0; m_left = 0; m_lenerr = 1'b0; n_lenerr = 0;
    rst = 1'b1;
    out_ready = 1'b0;

    // Reset with every VC holding two single-flit packets.
    for (int v = 0; v < NV; v++) begin
      push(v, hdr(4'h0, 0));
      push(v, hdr(4'h1, 0));
    end
    cycle();
    cycle();
    rst = 1'b0;
    drive_inputs();
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(1));
    chk("rst_active_vc", 64'(active_vc), 64'(0));
    chk("rst_locked", 64'(locked), 64'(0));
    chk("rst_vc_ren", 64'(vc_ren), 64'(0));
    chk("rst_len_err", 64'(len_err), 64'(0));
    cycle();

    // Round-robin with one-flit packets.
    clear_logs();
    out_ready = 1'b1;
    drain(40);
    chk("rr_count", 64'(glog.size()), 64'(8));
    chk("rr_g0", 64'(glog[0]), 64'(0));
    chk("rr_g1", 64'(glog[1]), 64'(1));
    chk("rr_g2", 64'(glog[2]), 64'(2));
    chk("rr_g3", 64'(glog[3]), 64'(3));
    chk("rr_g4", 64'(glog[4]), 64'(0));
    chk("rr_g5", 64'(glog[5]), 64'(1));

    // Long write of 5 flits on VC0.
    flush();
    clear_logs();
    push_pkt(0, hdr(4'h3, 3), 5);
    drain(40);
    chk("lw_count", 64'(glog.size()), 64'(5));
    chk("lw_all_vc0", 64'(glog[0] + glog[1] + glog[2] + glog[3] + glog[4]), 64'(0));
    chk("lw_sop", 64'({slog[0], slog[1], slog[2], slog[3], slog[4]}), 64'(5'b10000));
    chk("lw_eop", 64'({elog[0], elog[1], elog[2], elog[3], elog[4]}), 64'(5'b00001));
    chk("lw_locked", 64'({blog[0], blog[1], blog[2], blog[3], blog[4]}), 64'(5'b01111));

    // Packet lock versus a competitor that arrives after the header.
    flush();
    clear_logs();
    push_pkt(1, hdr(4'h1, 3), 4);
    cycle();
    push(0, hdr(4'h0, 0));
    drain(40);
    chk("lock_count", 64'(glog.size()), 64'(5));
    chk("lock_order", 64'({glog[0][3:0], glog[1][3:0], glog[2][3:0], glog[3][3:0], glog[4][3:0]}),
        64'(20'h11110));

    // Stall then bubble in the middle of a 6-flit packet on VC2, VC3 waiting.
    flush();
    clear_logs();
    push_pkt(2, hdr(4'h2, 4), 6);
    push(3, hdr(4'h0, 0));
    cycle();
    cycle();
    out_ready = 1'b0;
    repeat (3) cycle();
    out_ready = 1'b1;
    mask[2] = 1'b1;
    repeat (2) cycle();
    mask[2] = 1'b0;
    drain(40);
    chk("stall_count", 64'(glog.size()), 64'(7));
    chk("stall_order", 64'({glog[0][3:0], glog[1][3:0], glog[2][3:0], glog[3][3:0],
                            glog[4][3:0], glog[5][3:0], glog[6][3:0]}), 64'(28'h2222223));
    chk("stall_eop", 64'({elog[5], elog[6]}), 64'(2'b11));

    // Over-long header: payload 20 declares 22 flits.
    flush();
    clear_logs();
    n_lenerr = 0;
    push_pkt(0, hdr(4'h3, 20), 22);
    drain(80);
    first_eop = -1;
    for (int i = elog.size() - 1; i >= 0; i--) if (elog[i]) first_eop = i;
    chk("len_flits", 64'(glog.size()), 64'(22));
    chk("len_first_eop", 64'(first_eop), CHK ? 64'(15) : 64'(21));
    chk("len_err_pulses", 64'(n_lenerr), CHK ? 64'(1) : 64'(0));

    // Reset in the middle of a packet abandons the lock.
    flush();
    clear_logs();
    push_pkt(3, hdr(4'h3, 5), 7);
    cycle();
    cycle();
    rst = 1'b1;
    out_ready = 1'b0;
    flush();
    cycle();
    rst = 1'b0;
    drive_inputs();
    #1;
    chk("mrst_locked", 64'(locked), 64'(0));
    chk("mrst_out_valid", 64'(out_valid), 64'(0));
    chk("mrst_active_vc", 64'(active_vc), 64'(0));
    clear_logs();
    out_ready = 1'b1;
    push(1, hdr(4'h0, 0));
    push(2, hdr(4'h0, 0));
    drain(20);
    chk("mrst_count", 64'(glog.size()), 64'(2));
    chk("mrst_order", 64'({glog[0][3:0], glog[1][3:0]}), 64'(8'h12));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
